// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: scoreboards long-latency destinations, stalls decode on hazards,
// and arbitrates the single write port between pipeline and LU writeback with a starvation guard.
module regfile_wb_scheduler #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic        dec_wr,
    input  logic        dec_long,
    output logic        dec_stall,

    input  logic        pipe_wb_valid,
    input  logic [4:0]  pipe_wb_addr,
    input  logic [31:0] pipe_wb_data,
    output logic        pipe_hold,

    input  logic        lu_wb_valid,
    input  logic [4:0]  lu_wb_addr,
    input  logic [31:0] lu_wb_data,
    output logic        lu_wb_ready,

    output logic        rf_regwrite,
    output logic [4:0]  rf_writereg_addr,
    output logic [31:0] rf_writedata,

    output logic [31:0] busy,
    output logic        sb_err
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [31:0] busy_q, busy_d;
    logic        sb_err_q, sb_err_d;
    logic [3:0]  starve_q, starve_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        hit1, hit2, hitd;
    logic        issue;
    logic        pipe_grant, lu_grant;
    logic [4:0]  grant_addr;
    logic [31:0] grant_data;

    // Hazards are evaluated against the registered scoreboard only, so a clear
    // landing this cycle does not release the stall until the next one.
    always_comb begin
        hit1      = dec_use_rs1 & (dec_rs1 != 5'd0) & busy_q[dec_rs1];
        hit2      = dec_use_rs2 & (dec_rs2 != 5'd0) & busy_q[dec_rs2];
        hitd      = dec_wr      & (dec_rd  != 5'd0) & busy_q[dec_rd];
        dec_stall = dec_valid & (hit1 | hit2 | hitd);
    end

    always_comb begin
        pipe_hold   = lu_wb_valid & (starve_q == STARVE_LIM);
        lu_wb_ready = lu_wb_valid & (~pipe_wb_valid | pipe_hold);
        pipe_grant  = pipe_wb_valid & ~pipe_hold;
        lu_grant    = lu_wb_ready;
        issue       = dec_valid & ~dec_stall & ~pipe_hold;
    end

    always_comb begin
        grant_addr = 5'd0;
        grant_data = 32'd0;
        if (pipe_grant) begin
            grant_addr = pipe_wb_addr;
            grant_data = pipe_wb_data;
        end else if (lu_grant) begin
            grant_addr = lu_wb_addr;
            grant_data = lu_wb_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (lu_grant) begin
            busy_d[lu_wb_addr] = 1'b0;
        end
        // WAW stall guarantees this never collides with the clear above.
        if (issue & dec_long & dec_wr & (dec_rd != 5'd0)) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        sb_err_d = sb_err_q;
        if (lu_grant & (lu_wb_addr != 5'd0) & ~busy_q[lu_wb_addr]) begin
            sb_err_d = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (~lu_wb_valid | lu_grant) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Address/data only move on a real write; x0 grants complete but leave them alone.
    always_comb begin
        regwrite_d = (pipe_grant | lu_grant) & (grant_addr != 5'd0);
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (regwrite_d) begin
            wr_addr_d = grant_addr;
            wr_data_d = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 32'd0;
            sb_err_q   <= 1'b0;
            starve_q   <= 4'd0;
            regwrite_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 32'd0;
        end else begin
            busy_q     <= busy_d;
            sb_err_q   <= sb_err_d;
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy             = busy_q;
    assign sb_err           = sb_err_q;
    assign rf_regwrite      = regwrite_q;
    assign rf_writereg_addr = wr_addr_q;
    assign rf_writedata     = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a randomized run against a behavioural model.
module tb_regfile_wb_scheduler;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_wr, dec_long;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_stall;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        pipe_hold;
    logic        lu_wb_valid;
    logic [4:0]  lu_wb_addr;
    logic [31:0] lu_wb_data;
    logic        lu_wb_ready;
    logic        rf_regwrite;
    logic [4:0]  rf_writereg_addr;
    logic [31:0] rf_writedata;
    logic [31:0] busy;
    logic        sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit        m_busy[32];
    int        m_starve;
    bit        m_err;
    bit        m_we;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit        e_stall, e_hold, e_ready;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr(dec_wr), .dec_long(dec_long),
        .dec_stall(dec_stall),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
        .pipe_hold(pipe_hold),
        .lu_wb_valid(lu_wb_valid), .lu_wb_addr(lu_wb_addr), .lu_wb_data(lu_wb_data),
        .lu_wb_ready(lu_wb_ready),
        .rf_regwrite(rf_regwrite), .rf_writereg_addr(rf_writereg_addr), .rf_writedata(rf_writedata),
        .busy(busy), .sb_err(sb_err)
    );

    function automatic bit [31:0] model_busy_vec();
        bit [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic void calc();
        bit h1, h2, hd;
        h1 = dec_use_rs1 && dec_rs1 != 0 && m_busy[dec_rs1];
        h2 = dec_use_rs2 && dec_rs2 != 0 && m_busy[dec_rs2];
        hd = dec_wr && dec_rd != 0 && m_busy[dec_rd];
        e_stall = dec_valid && (h1 || h2 || hd);
        e_hold  = lu_wb_valid && (m_starve == SM);
        e_ready = lu_wb_valid && (!pipe_wb_valid || e_hold);
    endfunction

    // Advance model and DUT by one clock; returns at posedge + 1.
    task automatic tick();
        bit pg, lg, err_now;
        bit [4:0] a;
        bit [31:0] d;
        calc();
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_starve = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            pg = pipe_wb_valid && !e_hold;
            lg = e_ready;
            err_now = lg && lu_wb_addr != 0 && !m_busy[lu_wb_addr];
            if (err_now) m_err = 1;
            if (lg) m_busy[lu_wb_addr] = 0;
            if (dec_valid && !e_stall && !e_hold && dec_long && dec_wr && dec_rd != 0)
                m_busy[dec_rd] = 1;
            if (!lu_wb_valid || lg) m_starve = 0;
            else if (m_starve < SM) m_starve++;
            a = pg ? pipe_wb_addr : lu_wb_addr;
            d = pg ? pipe_wb_data : lu_wb_data;
            m_we = (pg || lg) && a != 0;
            if (m_we) begin
                m_addr = a;
                m_data = d;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr = 0; dec_long = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        pipe_wb_valid = 0; pipe_wb_addr = 0; pipe_wb_data = 0;
        lu_wb_valid = 0; lu_wb_addr = 0; lu_wb_data = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        dec_valid = 1; dec_wr = 1; dec_long = 1; dec_rd = rd;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        pipe_wb_valid = 1; pipe_wb_addr = 5'd3; pipe_wb_data = 32'h1234;
        rst = 1;
        tick();
        tick();
        rst = 0;
        idle();
        #1;
        n_checks++;
        if (busy !== 32'd0 || sb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_state busy=%h sb_err=%b want busy=0 sb_err=0", busy, sb_err);
        end
        n_checks++;
        if (rf_regwrite !== 1'b0 || rf_writereg_addr !== 5'd0 || rf_writedata !== 32'd0) begin
            n_fail++; $display("FAIL reset_wport we=%b addr=%0d data=%h want 0/0/0",
                               rf_regwrite, rf_writereg_addr, rf_writedata);
        end
        n_checks++;
        if (dec_stall !== 1'b0 || pipe_hold !== 1'b0 || lu_wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_comb stall=%b hold=%b ready=%b want 0/0/0",
                               dec_stall, pipe_hold, lu_wb_ready);
        end
    endtask

    task automatic test_raw();
        issue_long(5'd5);
        n_checks++;
        if (busy[5] !== 1'b1) begin
            n_fail++; $display("FAIL raw_busy_set busy=%h want bit5=1", busy);
        end
        dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd5; dec_wr = 1; dec_rd = 5'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (dec_stall !== 1'b1) begin
                n_fail++; $display("FAIL raw_stall cyc=%0d stall=%b want 1", i, dec_stall);
            end
            tick();
        end
        lu_wb_valid = 1; lu_wb_addr = 5'd5; lu_wb_data = 32'h0000_0055;
        #1;
        n_checks++;
        if (lu_wb_ready !== 1'b1 || dec_stall !== 1'b1) begin
            n_fail++; $display("FAIL raw_clear_cycle ready=%b stall=%b want 1/1", lu_wb_ready, dec_stall);
        end
        tick();
        lu_wb_valid = 0;
        n_checks++;
        if (busy[5] !== 1'b0 || rf_regwrite !== 1'b1 || rf_writereg_addr !== 5'd5 || rf_writedata !== 32'h55) begin
            n_fail++; $display("FAIL raw_lu_write busy=%h we=%b addr=%0d data=%h want bit5=0 1/5/55",
                               busy, rf_regwrite, rf_writereg_addr, rf_writedata);
        end
        #1;
        n_checks++;
        if (dec_stall !== 1'b0) begin
            n_fail++; $display("FAIL raw_unstall stall=%b want 0", dec_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_starvation();
        issue_long(5'd12);
        pipe_wb_valid = 1;
        lu_wb_valid = 1; lu_wb_addr = 5'd12; lu_wb_data = 32'hCAFE_0012;
        for (int i = 0; i < SM; i++) begin
            pipe_wb_addr = 5'(i + 1); pipe_wb_data = 32'h1000 + 32'(i);
            #1;
            n_checks++;
            if (pipe_hold !== 1'b0 || lu_wb_ready !== 1'b0) begin
                n_fail++; $display("FAIL starve_pipe_win cyc=%0d hold=%b ready=%b want 0/0", i, pipe_hold, lu_wb_ready);
            end
            tick();
            n_checks++;
            if (rf_regwrite !== 1'b1 || rf_writereg_addr !== 5'(i + 1) || rf_writedata !== 32'h1000 + 32'(i)) begin
                n_fail++; $display("FAIL starve_pipe_write cyc=%0d we=%b addr=%0d data=%h want 1/%0d/%h",
                                   i, rf_regwrite, rf_writereg_addr, rf_writedata, i + 1, 32'h1000 + i);
            end
        end
        pipe_wb_addr = 5'd20; pipe_wb_data = 32'h2020;
        #1;
        n_checks++;
        if (pipe_hold !== 1'b1 || lu_wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL starve_force hold=%b ready=%b want 1/1", pipe_hold, lu_wb_ready);
        end
        tick();
        n_checks++;
        if (rf_regwrite !== 1'b1 || rf_writereg_addr !== 5'd12 || rf_writedata !== 32'hCAFE_0012) begin
            n_fail++; $display("FAIL starve_lu_write we=%b addr=%0d data=%h want 1/12/cafe0012",
                               rf_regwrite, rf_writereg_addr, rf_writedata);
        end
        #1;
        n_checks++;
        if (pipe_hold !== 1'b0 || lu_wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL starve_counter_clear hold=%b ready=%b want 0/0", pipe_hold, lu_wb_ready);
        end
        tick();
        n_checks++;
        if (rf_writereg_addr !== 5'd20 || rf_writedata !== 32'h2020) begin
            n_fail++; $display("FAIL starve_held_payload addr=%0d data=%h want 20/2020", rf_writereg_addr, rf_writedata);
        end
        idle();
        tick();
    endtask

    task automatic test_x0();
        issue_long(5'd0);
        dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd0;
        #1;
        n_checks++;
        if (busy !== 32'd0 || dec_stall !== 1'b0) begin
            n_fail++; $display("FAIL x0_no_hazard busy=%h stall=%b want 0/0", busy, dec_stall);
        end
        tick();
        idle();
        lu_wb_valid = 1; lu_wb_addr = 5'd0; lu_wb_data = 32'hDEAD_0000;
        #1;
        n_checks++;
        if (lu_wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL x0_lu_accept ready=%b want 1", lu_wb_ready);
        end
        tick();
        idle();
        n_checks++;
        if (rf_regwrite !== 1'b0 || sb_err !== 1'b0 || rf_writedata === 32'hDEAD_0000) begin
            n_fail++; $display("FAIL x0_no_write we=%b sb_err=%b data=%h want we=0 sb_err=0 data unchanged",
                               rf_regwrite, sb_err, rf_writedata);
        end
    endtask

    task automatic test_waw();
        issue_long(5'd7);
        dec_valid = 1; dec_wr = 1; dec_rd = 5'd7;
        #1;
        n_checks++;
        if (dec_stall !== 1'b1) begin
            n_fail++; $display("FAIL waw_stall stall=%b want 1", dec_stall);
        end
        tick();
        lu_wb_valid = 1; lu_wb_addr = 5'd7; lu_wb_data = 32'h77;
        tick();
        lu_wb_valid = 0;
        #1;
        n_checks++;
        if (dec_stall !== 1'b0 || busy[7] !== 1'b0 || sb_err !== 1'b0) begin
            n_fail++; $display("FAIL waw_release stall=%b busy=%h sb_err=%b want 0/bit7=0/0", dec_stall, busy, sb_err);
        end
        tick();
        idle();
    endtask

    task automatic test_sb_err_and_reset();
        idle();
        lu_wb_valid = 1; lu_wb_addr = 5'd9; lu_wb_data = 32'h99;
        tick();
        idle();
        n_checks++;
        if (sb_err !== 1'b1) begin
            n_fail++; $display("FAIL sb_err_set sb_err=%b want 1", sb_err);
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (sb_err !== 1'b1) begin
            n_fail++; $display("FAIL sb_err_sticky sb_err=%b want 1", sb_err);
        end
        issue_long(5'd5);
        issue_long(5'd7);
        n_checks++;
        if (busy !== 32'h0000_00A0) begin
            n_fail++; $display("FAIL mid_busy busy=%h want 000000a0", busy);
        end
        dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd7;
        pipe_wb_valid = 1; pipe_wb_addr = 5'd3; pipe_wb_data = 32'h3333;
        rst = 1;
        #1;
        n_checks++;
        if (dec_stall !== 1'b1) begin
            n_fail++; $display("FAIL mid_stall stall=%b want 1", dec_stall);
        end
        tick();
        rst = 0;
        n_checks++;
        if (busy !== 32'd0 || rf_regwrite !== 1'b0 || sb_err !== 1'b0 || dec_stall !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset busy=%h we=%b sb_err=%b stall=%b want 0/0/0/0",
                               busy, rf_regwrite, sb_err, dec_stall);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        bit held;
        int pend[$];
        held = 0;
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_rs1     = 5'($urandom_range(0, 15));
            dec_rs2     = 5'($urandom_range(0, 15));
            dec_rd      = 5'($urandom_range(0, 15));
            dec_use_rs1 = $urandom_range(0, 1);
            dec_use_rs2 = $urandom_range(0, 1);
            dec_wr      = ($urandom_range(0, 3) != 0);
            dec_long    = ($urandom_range(0, 2) == 0);
            if (!held) begin
                pipe_wb_valid = ($urandom_range(0, 4) != 0);
                pipe_wb_addr  = 5'($urandom_range(0, 31));
                pipe_wb_data  = $urandom;
            end
            pend.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) pend.push_back(i);
            lu_wb_valid = ($urandom_range(0, 2) == 0);
            if (pend.size() != 0 && $urandom_range(0, 9) < 8)
                lu_wb_addr = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                lu_wb_addr = 5'($urandom_range(0, 31));
            lu_wb_data = $urandom;
            #1;
            calc();
            n_checks++;
            if (dec_stall !== e_stall || pipe_hold !== e_hold || lu_wb_ready !== e_ready) begin
                n_fail++; $display("FAIL rand_comb cyc=%0d stall/hold/ready=%b%b%b want %b%b%b",
                                   c, dec_stall, pipe_hold, lu_wb_ready, e_stall, e_hold, e_ready);
            end
            held = e_hold && !rst;
            tick();
            n_checks++;
            if (rf_regwrite !== m_we || rf_writereg_addr !== m_addr || rf_writedata !== m_data) begin
                n_fail++; $display("FAIL rand_wport cyc=%0d we=%b addr=%0d data=%h want %b/%0d/%h",
                                   c, rf_regwrite, rf_writereg_addr, rf_writedata, m_we, m_addr, m_data);
            end
            n_checks++;
            if (busy !== model_busy_vec() || sb_err !== m_err) begin
                n_fail++; $display("FAIL rand_sb cyc=%0d busy=%h sb_err=%b want %h/%b",
                                   c, busy, sb_err, model_busy_vec(), m_err);
            end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_raw();
        test_starvation();
        test_x0();
        test_waw();
        test_sb_err_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Controls the single write port of the 32x32 register file in the pipelined RISC-V core.
- Keeps a per-register scoreboard of pending long-latency results (loads/mul/div unit, "LU").
- Stalls decode on RAW/WAW hazards against those pending results.
- Arbitrates the write port between the in-order pipeline writeback stage and the LU writeback, with a starvation guard.

Parameters:
STARVE_MAX, 4, consecutive cycles LU may be refused before pipe_hold forces an LU grant (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
dec_valid  in  1  instruction present in decode
dec_rs1  in  5  source 1 address
dec_rs2  in  5  source 2 address
dec_rd  in  5  destination address
dec_use_rs1  in  1  instruction reads rs1
dec_use_rs2  in  1  instruction reads rs2
dec_wr  in  1  instruction writes rd
dec_long  in  1  result returns via LU, not the pipeline
dec_stall  out  1  hold decode this cycle (combinational)
pipe_wb_valid  in  1  pipeline writeback request (cannot be back-pressured, except by pipe_hold)
pipe_wb_addr  in  5  pipeline writeback address
pipe_wb_data  in  32  pipeline writeback data
pipe_hold  out  1  freeze writeback stage this cycle (combinational)
lu_wb_valid  in  1  LU writeback request
lu_wb_addr  in  5  LU writeback address
lu_wb_data  in  32  LU writeback data
lu_wb_ready  out  1  LU request accepted this cycle (combinational)
rf_regwrite  out  1  register file write enable (registered)
rf_writereg_addr  out  5  register file write address (registered)
rf_writedata  out  32  register file write data (registered)
busy  out  32  scoreboard vector, bit n = xn pending; bit 0 always 0
sb_err  out  1  sticky: LU wrote a non-busy register

Behaviour:
Reset and clocking:
- Single clock domain.
- rst sampled on the clk rising edge, active high.

Reset values:
- busy = 0, sb_err = 0, starve counter = 0.
- rf_regwrite = 0, rf_writereg_addr = 0, rf_writedata = 0.
- Reset mid-operation drops all pending busy bits and any in-flight grant.
- The first cycle after reset has rf_regwrite = 0.

Hazard check, combinational on current busy:
- hit1 = dec_use_rs1 & busy[dec_rs1]
- hit2 = dec_use_rs2 & busy[dec_rs2]
- hitd = dec_wr & busy[dec_rd] (WAW)
- dec_stall = dec_valid & (hit1 | hit2 | hitd)
- Address 0 never hits.

Issue and scoreboard:
- Issue = dec_valid & ~dec_stall & ~pipe_hold.
- On issue with dec_long & dec_wr & dec_rd != 0: set busy[dec_rd] at the next edge.
- Clear: busy[lu_wb_addr] is cleared at the edge where the LU handshake completes.
- Same-cycle clear and new set cannot target the same register, because the WAW stall prevents it.
- A clear does not unstall in the same cycle; the stalled instruction issues the following cycle.
- An LU handshake to a register with busy = 0, address 0 excluded, sets sb_err. sb_err is cleared only by rst.

Arbitration:
- pipe_hold = lu_wb_valid & (starve == STARVE_MAX).
- lu_wb_ready = lu_wb_valid & (~pipe_wb_valid | pipe_hold).
- Grant goes to the pipeline if pipe_wb_valid & ~pipe_hold; otherwise to the LU if lu_wb_valid; otherwise idle.
- While pipe_hold = 1, the top level stalls the whole pipeline, so the pipe writeback payload persists into the next cycle.
- Starve counter:
  - increments (saturating at STARVE_MAX) each cycle lu_wb_valid & ~lu_wb_ready;
  - clears on an LU grant or when lu_wb_valid = 0.

Write port:
- The granted request is registered, so the write reaches the register file exactly 1 cycle after the grant.
- rf_regwrite = 1 only if a grant occurred and its address != 0. An accepted LU write to x0 completes the handshake but performs no write.
- When rf_regwrite = 0, rf_writereg_addr and rf_writedata hold their previous values.

Test Plan:
- Issue long load to x5, then add reading x5 next cycle -> dec_stall = 1 and busy[5] = 1 until the LU writes x5. The add issues the cycle after the clear; rf_regwrite with addr 5 appears one cycle after lu_wb_ready.
- pipe_wb_valid and lu_wb_valid both high with STARVE_MAX = 4 -> pipeline granted 4 cycles. In cycle 5 pipe_hold = 1 and lu_wb_ready = 1, with the LU data on rf_writedata the next cycle; the counter then returns to 0.
- Long op with dec_rd = 0, then instruction using rs1 = 0 -> busy stays 0, no stall. LU write to x0 is accepted with rf_regwrite = 0.
- LU writeback to x9 while busy[9] = 0 -> sb_err = 1 and stays 1 until rst.
- Long op to x7, then dec_wr to x7 (WAW) -> stall until the x7 LU write completes.
- busy = 0x000000A0 with rst asserted mid-stall -> next cycle busy = 0, dec_stall = 0, rf_regwrite = 0, sb_err = 0.
